// File: rtl/jifenping_pkg.sv
// Shared types and default parameters for the
// clock-divider ratio sequencer.
package jifenping_pkg;

    localparam int JP_W       = 8;
    localparam int JP_DEF_N   = 4;
    localparam int JP_MIN_N   = 2;
    localparam int JP_MAX_N   = 255;
    localparam int JP_RST_CYC = 2;
    localparam int JP_SET_PER = 2;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        WAIT,
        LOAD,
        SETTLE
    } state_t;

endpackage

// File: rtl/jifenping_if.sv
// Requester-side handshake bundle: two ratio
// requests in, grant/error/done pulses out.
interface jifenping_if
    import jifenping_pkg::*;
#(
    parameter int W = JP_W
);
    logic         req0;
    logic [W-1:0] n0;
    logic         req1;
    logic [W-1:0] n1;
    logic         gnt0;
    logic         gnt1;
    logic         err;
    logic         done;

    modport master (
        output req0, n0, req1, n1,
        input  gnt0, gnt1, err, done
    );

    modport slave (
        input  req0, n0, req1, n1,
        output gnt0, gnt1, err, done
    );
endinterface

// File: rtl/jifenping_rr_arb2.sv
// Two-way round-robin arbiter; one-hot grant,
// last-winner flag moves only on a real grant.
module jifenping_rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    logic last;

    // Pick the requester that did not win last time on a tie
    always_comb begin
        gnt = 2'b00;
        if (en) begin
            unique case (req)
                2'b11:   gnt = last ? 2'b01 : 2'b10;
                default: gnt = req;
            endcase
        end
    end

    // Remember the last winner; out of reset req0 is favoured
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last <= 1'b1;
        end else if (|gnt) begin
            last <= gnt[1];
        end
    end
endmodule

// File: rtl/jifenping_ctrl.sv
// Ratio sequencer: arbitrates requests, applies a new ratio at a
// divider period boundary, resets the divider, then settles to lock.
module jifenping_ctrl
    import jifenping_pkg::*;
#(
    parameter int W       = JP_W,
    parameter int DEF_N   = JP_DEF_N,
    parameter int MIN_N   = JP_MIN_N,
    parameter int MAX_N   = JP_MAX_N,
    parameter int RST_CYC = JP_RST_CYC,
    parameter int SET_PER = JP_SET_PER
) (
    input  logic         clk,
    input  logic         reset,
    jifenping_if.slave   rq,
    output logic         busy,
    output logic         lock,
    output logic [W-1:0] div_n,
    output logic         div_rst
);
    localparam logic [W-1:0] N_RST = DEF_N[W-1:0];
    localparam logic [W:0]   N_LO  = MIN_N[W:0];
    localparam logic [W:0]   N_HI  = MAX_N[W:0];
    localparam logic [W+1:0] RC    = RST_CYC[W+1:0];
    localparam logic [W+1:0] SP    = SET_PER[W+1:0];

    state_t       state;
    state_t       state_nxt;
    logic [W-1:0] pcnt;
    logic [W-1:0] pend_n;
    logic [W+1:0] cnt;
    logic [W+1:0] settle_len;
    logic [1:0]   gnt;
    logic [W-1:0] win_n;
    logic         arb_en;
    logic         bnd;
    logic         legal;
    logic         same;
    logic         rst_last;
    logic         set_last;
    logic         from_load;
    logic         done_q;

    assign arb_en     = (state == IDLE);
    assign win_n      = gnt[1] ? rq.n1 : rq.n0;
    assign legal      = ({1'b0, win_n} >= N_LO) && ({1'b0, win_n} <= N_HI);
    assign same       = (win_n == div_n);
    assign bnd        = (pcnt == div_n - 1'b1);
    assign settle_len = SP * {2'b00, div_n};
    assign rst_last   = (cnt == RC - 1'b1);
    assign set_last   = (cnt == settle_len - 1'b1);

    assign rq.gnt0 = gnt[0];
    assign rq.gnt1 = gnt[1];
    assign rq.err  = (|gnt) && !legal;
    assign rq.done = done_q;

    jifenping_rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .en    (arb_en),
        .req   ({rq.req1, rq.req0}),
        .gnt   (gnt)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and per-state divider controls
    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        lock      = 1'b0;
        div_rst   = 1'b0;
        unique case (state)
            INIT: begin
                div_rst = 1'b1;
                if (rst_last) state_nxt = SETTLE;
            end
            IDLE: begin
                busy = 1'b0;
                lock = 1'b1;
                if ((|gnt) && legal && !same) state_nxt = WAIT;
            end
            WAIT: begin
                lock = 1'b1;
                if (bnd) state_nxt = LOAD;
            end
            LOAD: begin
                div_rst = 1'b1;
                if (rst_last) state_nxt = SETTLE;
            end
            SETTLE: begin
                if (set_last) state_nxt = IDLE;
            end
            default: state_nxt = INIT;
        endcase
    end

    // Dwell counter for the reset and settle windows
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (state_nxt != state) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Divider period tracker, held at zero while the divider is in reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pcnt <= '0;
        end else if (div_rst || bnd) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + 1'b1;
        end
    end

    // Capture the winner's ratio and apply it only at a period boundary
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_n <= '0;
            div_n  <= N_RST;
        end else begin
            if (|gnt) pend_n <= win_n;
            if (state == WAIT && bnd) div_n <= pend_n;
        end
    end

    // Settle origin and the done pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            from_load <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            if (state != SETTLE) from_load <= (state == LOAD);
            done_q <= (state == SETTLE && set_last && from_load)
                   || (state == IDLE && (|gnt) && legal && same);
        end
    end
endmodule

// File: tb/tb_jifenping_ctrl.sv
// Bench for jifenping_ctrl: schedule-based reference model checked
// every cycle, directed scenarios plus a randomized request run.
module tb_jifenping_ctrl;
    import jifenping_pkg::*;

    localparam int RST = 2;
    localparam int SET = 2;
    localparam int DEF = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       busy;
    logic       lock;
    logic       div_rst;
    logic [7:0] div_n;

    jifenping_if #(.W(8)) bus ();

    jifenping_ctrl dut (
        .clk     (clk),
        .reset   (reset),
        .rq      (bus),
        .busy    (busy),
        .lock    (lock),
        .div_n   (div_n),
        .div_rst (div_rst)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc;

    // model: absolute cycle schedule of the current configuration
    int m_n, rst_end, idle_at, t0, done_at, pend, last;
    bit waiting, mg0, mg1;

    bit arm0, arm1, rnd;
    logic [7:0] an0, an1;
    int first_lock, first_rise, first_done;
    int n_err, n_done, n_rise;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_init();
        m_n = DEF;
        rst_end = RST;
        t0 = RST;
        idle_at = RST + SET * DEF;
        done_at = -1;
        waiting = 0;
        last = 1;
        mg0 = 0;
        mg1 = 0;
    endtask

    function automatic logic [7:0] pick();
        int r;
        r = int'($urandom_range(0, 63));
        if (r < 6) return 8'(r % 2);
        if (r < 14) return 8'(m_n);
        if (r == 63) return 8'd255;
        return 8'($urandom_range(2, 12));
    endfunction

    task automatic eval_cycle();
        bit e_rst, e_lock, e_busy, e_err, e_done, g0, g1, bnd;
        int w, nw;
        e_rst  = cyc < rst_end;
        e_lock = cyc >= idle_at;
        e_busy = !(cyc >= idle_at && !waiting);
        e_done = (cyc == done_at);
        g0 = 0; g1 = 0; e_err = 0; w = 0; nw = 0;
        if (!e_busy && (bus.req0 || bus.req1)) begin
            if (bus.req0 && bus.req1) w = 1 - last;
            else w = bus.req0 ? 0 : 1;
            g0 = (w == 0);
            g1 = (w == 1);
            nw = w == 1 ? int'(bus.n1) : int'(bus.n0);
            e_err = (nw < 2) || (nw > 255);
        end
        bnd = (cyc >= t0) && (((cyc - t0) % m_n) == m_n - 1);
        chk("ctl", int'({bus.gnt0, bus.gnt1, bus.err, bus.done,
                         busy, lock, div_rst}),
                   int'({g0, g1, e_err, e_done, e_busy, e_lock, e_rst}));
        chk("div_n", int'(div_n), m_n);
        if (lock && first_lock < 0) first_lock = cyc;
        if (div_rst && cyc >= RST && first_rise < 0) first_rise = cyc;
        if (bus.done && first_done < 0) first_done = cyc;
        if (bus.err) n_err++;
        if (bus.done) n_done++;
        if (div_rst && cyc >= RST) n_rise++;
        mg0 = g0;
        mg1 = g1;
        if (g0 || g1) begin
            last = w;
            if (!e_err) begin
                if (nw == m_n) done_at = cyc + 1;
                else begin
                    waiting = 1;
                    pend = nw;
                end
            end
        end else if (waiting && bnd) begin
            rst_end = cyc + 1 + RST;
            m_n = pend;
            t0 = rst_end;
            idle_at = rst_end + SET * pend;
            done_at = idle_at;
            waiting = 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (mg0) bus.req0 = 1'b0;
        if (mg1) bus.req1 = 1'b0;
        if (arm0) begin bus.req0 = 1'b1; bus.n0 = an0; arm0 = 0; end
        if (arm1) begin bus.req1 = 1'b1; bus.n1 = an1; arm1 = 0; end
        if (rnd) begin
            if (!bus.req0 && $urandom_range(0, 3) == 0) begin
                bus.req0 = 1'b1; bus.n0 = pick();
            end
            if (!bus.req1 && $urandom_range(0, 3) == 0) begin
                bus.req1 = 1'b1; bus.n1 = pick();
            end
        end
        @(negedge clk);
        eval_cycle();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.n0 = '0; bus.n1 = '0;
        arm0 = 0; arm1 = 0;
        repeat (2) begin
            @(negedge clk);
            chk("rst_ctl", int'({bus.gnt0, bus.gnt1, bus.err, bus.done,
                                 busy, lock, div_rst}), 'b0000101);
            chk("rst_div_n", int'(div_n), 4);
        end
        @(posedge clk);
        #1 reset = 1'b1;
        cyc = 0;
        model_init();
        first_lock = -1; first_rise = -1; first_done = -1;
        n_err = 0; n_done = 0; n_rise = 0;
        @(negedge clk);
        eval_cycle();
    endtask

    initial begin
        int k;
        rnd = 0;
        arm0 = 0; arm1 = 0;

        // 1: bring-up
        do_reset();
        repeat (12) step();
        chk("t1_lock_cyc", first_lock, 10);
        chk("t1_no_done", n_done, 0);

        // 2: 4 -> 7 (req at cycle 13, boundary at 17)
        an0 = 8'd7; arm0 = 1;
        repeat (30) step();
        chk("t2_rise_cyc", first_rise, 18);
        chk("t2_done_cyc", first_done, 34);
        chk("t2_div_n", int'(div_n), 7);

        // 3: simultaneous requests
        do_reset();
        repeat (10) step();
        an0 = 8'd5; an1 = 8'd6; arm0 = 1; arm1 = 1;
        repeat (80) step();
        chk("t3_first_done", first_done, 26);
        chk("t3_div_n", int'(div_n), 6);

        // 4: illegal ratios
        n_err = 0; n_done = 0; n_rise = 0;
        an1 = 8'd1; arm1 = 1;
        step(); step();
        an1 = 8'd0; arm1 = 1;
        repeat (5) step();
        chk("t4_errs", n_err, 2);
        chk("t4_no_done", n_done, 0);
        chk("t4_div_n", int'(div_n), 6);

        // 5: same ratio
        n_done = 0; n_rise = 0;
        an0 = 8'd6; arm0 = 1;
        repeat (4) step();
        chk("t5_done", n_done, 1);
        chk("t5_no_rst", n_rise, 0);

        // 6: reset while loading 9
        an0 = 8'd9; arm0 = 1;
        k = 0;
        step();
        while (!(cyc < rst_end) && k < 40) begin
            step();
            k++;
        end
        chk("t6_load_seen", int'(cyc < rst_end), 1);
        #2 reset = 1'b0;
        #1;
        chk("t6_async", int'({bus.gnt0, bus.gnt1, bus.err, bus.done,
                              busy, lock, div_rst}), 'b0000101);
        chk("t6_div_n", int'(div_n), 4);
        do_reset();
        repeat (12) step();
        chk("t6_lock_cyc", first_lock, 10);

        // randomized traffic
        do_reset();
        rnd = 1;
        repeat (3000) step();
        rnd = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
